// File: rtl/beat_scheduler.sv
// Round-robin scheduler: splits each granted byte-length request into registered beats.
// First beat is valid the cycle after accept; beat outputs hold while beat_rdy_i is low.
module beat_scheduler #(
   parameter int N_REQ      = 4,
   parameter int BEAT_BYTES = 8,
   parameter int MAX_LEN    = 256,
   localparam int MAX_BEATS = (MAX_LEN + BEAT_BYTES - 1) / BEAT_BYTES,
   localparam int LEN_W     = $clog2(MAX_LEN + 1),
   localparam int ID_W      = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1,
   localparam int IDX_W     = ($clog2(MAX_BEATS) > 1) ? $clog2(MAX_BEATS) : 1,
   localparam int BB_W      = $clog2(BEAT_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_vld_i,
   input  logic [N_REQ*LEN_W-1:0] req_len_i,
   output logic [N_REQ-1:0]       req_rdy_o,
   output logic                   beat_vld_o,
   input  logic                   beat_rdy_i,
   output logic [ID_W-1:0]        beat_id_o,
   output logic [IDX_W-1:0]       beat_idx_o,
   output logic [BB_W-1:0]        beat_bytes_o,
   output logic                   beat_last_o,
   output logic                   busy_o
);
   localparam int               TOT_W      = IDX_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_LEN);
   localparam logic [BB_W-1:0]  FULL_BYTES = BB_W'(BEAT_BYTES);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t           state;
   logic [ID_W-1:0]  rr_ptr;
   logic [LEN_W-1:0] len_q;
   logic [TOT_W-1:0] total_q;

   logic             win_vld;
   logic [ID_W-1:0]  win_id;
   logic [ID_W-1:0]  cand;
   logic [ID_W-1:0]  nxt_ptr;
   logic [LEN_W-1:0] raw_len;
   logic [LEN_W-1:0] win_len;
   logic [TOT_W-1:0] win_total;
   logic [BB_W-1:0]  win_bytes;
   int               win_beats;

   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      cand    = '0;
      // Scan from the far end so the requester nearest rr_ptr overwrites last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
         if (req_vld_i[cand]) begin
            win_vld = 1'b1;
            win_id  = cand;
         end
      end
      raw_len = '0;
      for (int i = 0; i < N_REQ; i++)
         if (win_id == ID_W'(i)) raw_len = req_len_i[i*LEN_W +: LEN_W];
      win_len   = (raw_len > MAX_LEN_L) ? MAX_LEN_L : raw_len;
      win_beats = (int'(win_len) + BEAT_BYTES - 1) / BEAT_BYTES;
      win_total = TOT_W'(win_beats);
      win_bytes = (win_beats == 1) ? BB_W'(win_len) : FULL_BYTES;
      nxt_ptr   = ID_W'((int'(win_id) + 1) % N_REQ);
   end

   // Grant is suppressed during reset so nobody sees an accept that is then dropped.
   always_comb begin
      req_rdy_o = '0;
      if (state == IDLE && !rst) req_rdy_o[win_id] = win_vld;
   end

   logic [TOT_W-1:0] nxt_idx;
   logic             nxt_last;
   logic [BB_W-1:0]  last_bytes;

   assign nxt_idx    = {1'b0, beat_idx_o} + TOT_W'(1);
   assign nxt_last   = (nxt_idx == total_q - TOT_W'(1));
   assign last_bytes = BB_W'(int'(len_q) - (int'(total_q) - 1) * BEAT_BYTES);
   assign busy_o     = (state == ISSUE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         len_q        <= '0;
         total_q      <= '0;
         beat_vld_o   <= 1'b0;
         beat_id_o    <= '0;
         beat_idx_o   <= '0;
         beat_bytes_o <= '0;
         beat_last_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  rr_ptr  <= nxt_ptr;
                  len_q   <= win_len;
                  total_q <= win_total;
                  if (win_len != '0) begin
                     state        <= ISSUE;
                     beat_vld_o   <= 1'b1;
                     beat_id_o    <= win_id;
                     beat_idx_o   <= '0;
                     beat_bytes_o <= win_bytes;
                     beat_last_o  <= (win_total == TOT_W'(1));
                  end
               end
            end
            ISSUE: begin
               if (beat_rdy_i) begin
                  if (beat_last_o) begin
                     state       <= IDLE;
                     beat_vld_o  <= 1'b0;
                     beat_last_o <= 1'b0;
                  end else begin
                     beat_idx_o   <= nxt_idx[IDX_W-1:0];
                     beat_last_o  <= nxt_last;
                     beat_bytes_o <= nxt_last ? last_bytes : FULL_BYTES;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state == IDLE && win_vld) assert (raw_len <= MAX_LEN_L);
   end

endmodule

// File: tb/tb_beat_scheduler.sv
// Bench for beat_scheduler: vector table, directed corner sequences, randomized run vs queue model.
module tb_beat_scheduler;
   localparam int N_REQ = 4, BEAT_BYTES = 8, MAX_LEN = 256;
   localparam int LEN_W = 9, ID_W = 2, IDX_W = 5, BB_W = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_REQ-1:0]       req_vld_i, req_rdy_o;
   logic [N_REQ*LEN_W-1:0] req_len_i;
   logic                   beat_vld_o, beat_rdy_i, beat_last_o, busy_o;
   logic [ID_W-1:0]        beat_id_o;
   logic [IDX_W-1:0]       beat_idx_o;
   logic [BB_W-1:0]        beat_bytes_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   beat_scheduler #(.N_REQ(N_REQ), .BEAT_BYTES(BEAT_BYTES), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst(rst),
      .req_vld_i(req_vld_i), .req_len_i(req_len_i), .req_rdy_o(req_rdy_o),
      .beat_vld_o(beat_vld_o), .beat_rdy_i(beat_rdy_i), .beat_id_o(beat_id_o),
      .beat_idx_o(beat_idx_o), .beat_bytes_o(beat_bytes_o), .beat_last_o(beat_last_o),
      .busy_o(busy_o)
   );

   typedef struct { int id; int len; int nbeats; int last_bytes; } vec_t;
   typedef struct { int id; int idx; int bytes; int last; } beat_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_len(input int i, input int len);
      req_len_i[i*LEN_W +: LEN_W] = LEN_W'(len);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_vld_i = '0; req_len_i = '0; beat_rdy_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic chk_beat(input string tag, input int id, input int idx, input int bytes, input int last);
      chk({tag, "_vld"}, beat_vld_o, 1);
      chk({tag, "_id"}, beat_id_o, id);
      chk({tag, "_idx"}, beat_idx_o, idx);
      chk({tag, "_bytes"}, beat_bytes_o, bytes);
      chk({tag, "_last"}, beat_last_o, last);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdy"}, req_rdy_o, 0);
      chk({tag, "_vld"}, beat_vld_o, 0);
      chk({tag, "_id"}, beat_id_o, 0);
      chk({tag, "_idx"}, beat_idx_o, 0);
      chk({tag, "_bytes"}, beat_bytes_o, 0);
      chk({tag, "_last"}, beat_last_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
   endtask

   vec_t             vecs[8];
   beat_t            exp_q[$];
   beat_t            bt;
   logic [N_REQ-1:0] pend_vld, exp_rdy;
   int               pend_len[N_REQ];
   int               rr, w, n, r, exp_start;
   bit               found;

   initial begin
      vecs[0] = '{2, 20, 3, 4};
      vecs[1] = '{0, 16, 2, 8};
      vecs[2] = '{3, 1, 1, 1};
      vecs[3] = '{1, 8, 1, 8};
      vecs[4] = '{0, 256, 32, 8};
      vecs[5] = '{3, 9, 2, 1};
      vecs[6] = '{1, 7, 1, 7};
      vecs[7] = '{2, 255, 32, 7};

      // Reset values, sampled while rst is held and just after release
      rst = 1'b1; req_vld_i = '0; req_len_i = '0; beat_rdy_i = 1'b0;
      @(posedge clk);
      @(negedge clk) chk_zero("rst_hold");
      tick(); rst = 1'b0;
      @(negedge clk) chk_zero("rst_rel");

      // Single-requester vectors with beat_rdy_i tied high
      beat_rdy_i = 1'b1;
      for (int v = 0; v < 8; v++) begin
         tick();
         req_vld_i = 4'b1 << vecs[v].id;
         set_len(vecs[v].id, vecs[v].len);
         @(negedge clk);
         chk("tab_accept", req_rdy_o, 1 << vecs[v].id);
         chk("tab_vld_at_accept", beat_vld_o, 0);
         tick();
         req_vld_i = '0;
         for (int b = 0; b < vecs[v].nbeats; b++) begin
            @(negedge clk);
            chk_beat("tab", vecs[v].id, b,
                     (b == vecs[v].nbeats - 1) ? vecs[v].last_bytes : BEAT_BYTES,
                     (b == vecs[v].nbeats - 1) ? 1 : 0);
            chk("tab_busy", busy_o, 1);
            if (b != vecs[v].nbeats - 1) tick();
         end
         tick();
         @(negedge clk);
         chk("tab_idle_vld", beat_vld_o, 0);
         chk("tab_idle_busy", busy_o, 0);
      end

      // Zero-length request: consumed without beats, pointer moves past requester 1
      do_reset();
      beat_rdy_i = 1'b1;
      req_vld_i = 4'b0010; set_len(1, 0);
      @(negedge clk);
      chk("zl_accept", req_rdy_o, 4'b0010);
      tick();
      req_vld_i = '0;
      @(negedge clk);
      chk("zl_no_beat", beat_vld_o, 0);
      chk("zl_rdy_drop", req_rdy_o, 0);
      tick();
      req_vld_i = 4'b0110; set_len(1, 8); set_len(2, 8);
      @(negedge clk);
      chk("zl_ptr_adv", req_rdy_o, 4'b0100);
      tick();
      req_vld_i = '0;
      tick();
      // Back-to-back zero-length: one grant per cycle, continuing from requester 3
      req_vld_i = 4'b1111;
      for (int i = 0; i < N_REQ; i++) set_len(i, 0);
      exp_start = 3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("zl_b2b_grant", req_rdy_o, 1 << ((exp_start + k) % N_REQ));
         chk("zl_b2b_vld", beat_vld_o, 0);
         tick();
      end
      req_vld_i = '0;

      // Round robin with all four requesters continuously valid
      do_reset();
      beat_rdy_i = 1'b1;
      req_vld_i = 4'b1111;
      for (int i = 0; i < N_REQ; i++) set_len(i, 8);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rr_grant", req_rdy_o, 1 << (k % N_REQ));
         tick();
         @(negedge clk);
         chk("rr_rdy_busy", req_rdy_o, 0);
         chk_beat("rr", k % N_REQ, 0, 8, 1);
         tick();
      end
      req_vld_i = '0;

      // Downstream stall on beat 1 of a 24-byte transfer
      do_reset();
      beat_rdy_i = 1'b1;
      req_vld_i = 4'b0001; set_len(0, 24);
      @(negedge clk);
      chk("stall_accept", req_rdy_o, 1);
      tick();
      req_vld_i = '0;
      @(negedge clk);
      chk_beat("stall_b0", 0, 0, 8, 0);
      tick();
      beat_rdy_i = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk_beat("stall_hold", 0, 1, 8, 0);
         tick();
      end
      beat_rdy_i = 1'b1;
      @(negedge clk);
      chk_beat("stall_rel", 0, 1, 8, 0);
      tick();
      @(negedge clk);
      chk_beat("stall_end", 0, 2, 8, 1);
      tick();
      @(negedge clk);
      chk("stall_idle", beat_vld_o, 0);

      // Reset in the middle of a 4-beat transfer, with requesters 0 and 3 waiting
      do_reset();
      beat_rdy_i = 1'b1;
      req_vld_i = 4'b0001; set_len(0, 32);
      @(negedge clk);
      chk("mrst_accept", req_rdy_o, 1);
      tick();
      req_vld_i = '0;
      @(negedge clk);
      chk_beat("mrst_b0", 0, 0, 8, 0);
      tick();
      @(negedge clk);
      chk_beat("mrst_b1", 0, 1, 8, 0);
      rst = 1'b1;
      req_vld_i = 4'b1001; set_len(3, 8);
      tick();
      @(negedge clk);
      chk_zero("mrst_clear");
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_rr_reset", req_rdy_o, 4'b0001);

      // Randomized traffic against a queue-of-expected-beats model
      do_reset();
      rr = 0;
      pend_vld = '0;
      exp_rdy = '0;
      for (int i = 0; i < N_REQ; i++) pend_len[i] = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         tick();
         pend_vld = pend_vld & ~exp_rdy;
         for (int i = 0; i < N_REQ; i++) begin
            if (!pend_vld[i] && $urandom_range(0, 3) == 0) begin
               pend_vld[i] = 1'b1;
               r = $urandom_range(0, 9);
               pend_len[i] = (r == 0) ? 0 :
                             (r == 1) ? MAX_LEN :
                             (r <= 4) ? $urandom_range(1, BEAT_BYTES) :
                                        $urandom_range(1, MAX_LEN);
            end
            set_len(i, pend_len[i]);
         end
         req_vld_i = pend_vld;
         beat_rdy_i = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         exp_rdy = '0;
         if (exp_q.size() == 0) begin
            found = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
               w = (rr + k) % N_REQ;
               if (!found && pend_vld[w]) begin
                  found = 1'b1;
                  exp_rdy[w] = 1'b1;
               end
            end
         end
         chk("rnd_rdy", req_rdy_o, exp_rdy);
         chk("rnd_vld", beat_vld_o, (exp_q.size() != 0) ? 1 : 0);
         chk("rnd_busy", busy_o, (exp_q.size() != 0) ? 1 : 0);
         if (exp_q.size() != 0) begin
            bt = exp_q[0];
            chk("rnd_id", beat_id_o, bt.id);
            chk("rnd_idx", beat_idx_o, bt.idx);
            chk("rnd_bytes", beat_bytes_o, bt.bytes);
            chk("rnd_last", beat_last_o, bt.last);
            if (beat_rdy_i) void'(exp_q.pop_front());
         end else if (exp_rdy != '0) begin
            for (int k = 0; k < N_REQ; k++) if (exp_rdy[k]) w = k;
            rr = (w + 1) % N_REQ;
            n = (pend_len[w] + BEAT_BYTES - 1) / BEAT_BYTES;
            for (int b = 0; b < n; b++) begin
               bt.id    = w;
               bt.idx   = b;
               bt.bytes = (b == n - 1) ? pend_len[w] - b * BEAT_BYTES : BEAT_BYTES;
               bt.last  = (b == n - 1) ? 1 : 0;
               exp_q.push_back(bt);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/beat_scheduler.md
# beat_scheduler

Round-robin scheduler that shares one beat-wide datapath between `N_REQ` requesters. Each requester presents a byte-length transfer. The scheduler grants one requester at a time and splits the winner's transfer into `common_pkg::ceil(len, BEAT_BYTES)` beats. For each beat it drives the requester id, beat index, valid-byte count and a last flag to the downstream datapath under a valid/ready handshake. It sits between the requester ports and the shared datapath.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (≥2).
- `BEAT_BYTES`, default 8: bytes per datapath beat (≥1).
- `MAX_LEN`, default 256: maximum legal transfer length in bytes.
- Derived values, not overridable:
  - `MAX_BEATS = common_pkg::ceil(MAX_LEN, BEAT_BYTES)`
  - `LEN_W = $clog2(MAX_LEN+1)`
  - `ID_W = max(1, $clog2(N_REQ))`
  - `IDX_W = max(1, $clog2(MAX_BEATS))`
  - `BB_W = $clog2(BEAT_BYTES+1)`

Ports (clock and reset first):
- `clk`  in  1  — single clock; all logic on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_vld_i`  in  N_REQ  — per-requester request valid.
- `req_len_i`  in  N_REQ*LEN_W  — per-requester length in bytes; slice i is at `[i*LEN_W +: LEN_W]`.
- `req_rdy_o`  out  N_REQ  — one-hot accept; a request is taken when `req_vld_i[i] & req_rdy_o[i]`.
- `beat_vld_o`  out  1  — beat valid.
- `beat_rdy_i`  in  1  — downstream ready.
- `beat_id_o`  out  ID_W  — granted requester index.
- `beat_idx_o`  out  IDX_W  — beat number within the transfer, starting at 0.
- `beat_bytes_o`  out  BB_W  — valid bytes in this beat.
- `beat_last_o`  out  1  — final beat of the transfer.
- `busy_o`  out  1  — high while in ISSUE.

## Operation
- FSM has two states, IDLE and ISSUE; reset state is IDLE.
- Round-robin pointer `rr_ptr` resets to 0. Search order is `rr_ptr, rr_ptr+1, …` modulo `N_REQ`.
- **IDLE:**
  - `req_rdy_o` is combinational and one-hot to the first valid requester in search order; it is 0 if no requester is valid.
  - On accept, register `id`, `len` and `total = ceil(len, BEAT_BYTES)`, clear `idx`, and set `rr_ptr = (winner+1) mod N_REQ`.
  - If `len ≠ 0`, go to ISSUE.
  - If `len == 0`, the request is consumed with no beats, the FSM stays in IDLE, and `rr_ptr` still advances.
- **ISSUE:**
  - `req_rdy_o` = 0 and `beat_vld_o` = 1.
  - `beat_last_o = (idx == total-1)`.
  - `beat_bytes_o` is `BEAT_BYTES` on non-last beats. On the last beat it is `len - (total-1)*BEAT_BYTES`, a value in 1..`BEAT_BYTES`.
  - On `beat_vld_o & beat_rdy_i`: if last, go to IDLE; otherwise increment `idx`.
- Width and arithmetic rules:
  - `total` is computed at full integer width, then truncated to `IDX_W+1` bits.
  - `len > MAX_LEN` is illegal. A simulation assertion fires, and the length is clamped to `MAX_LEN`.
- Handshake stability: while `beat_vld_o` is high and `beat_rdy_i` is low, all `beat_*_o` outputs are held stable.
- Reset mid-transfer: the transfer is abandoned with no last beat emitted. The FSM returns to IDLE, `rr_ptr` returns to 0, and the requester must re-request.

## Timing
- Reset values: `req_rdy_o` = 0, `beat_vld_o` = 0, `beat_id_o` = 0, `beat_idx_o` = 0, `beat_bytes_o` = 0, `beat_last_o` = 0, `busy_o` = 0.
- Accept at cycle T gives `beat_vld_o` = 1 at T+1 with `beat_idx_o` = 0.
- All `beat_*_o` outputs and `busy_o` are registered. `req_rdy_o` is combinational from `req_vld_i` and state only, not from `req_len_i`.
- With `beat_rdy_i` tied high, an n-beat transfer occupies cycles T+1..T+n. The FSM is in IDLE at T+n+1, and the next accept can happen at T+n+1.
- Minimum spacing is one idle cycle between transfers, so throughput is n/(n+1).
- Back-to-back zero-length requests are accepted one per cycle.
- Simultaneous events:
  - A last-beat handshake and new requests in the same cycle: the new requests are not seen until the following IDLE cycle.
  - `rst` takes priority over all other inputs.

## Test plan
- Requester 2 sends `len`=20 with `BEAT_BYTES`=8 and `beat_rdy_i`=1 → three beats, all with id=2: `idx` 0/1/2, `bytes` 8/8/4, `last` high only on `idx`=2; `beat_vld_o` rises the cycle after accept.
- `len`=16, then `len`=1 → the first transfer gives beats 8/8 with last on the second; the second gives a single beat with `bytes`=1 and `last`=1.
- `len`=0 on requester 1 → `req_rdy_o[1]` pulses once, `beat_vld_o` stays 0, and `rr_ptr` advances to 2.
- All four requesters held valid with `len`=8 → grant order 0,1,2,3,0,1; each grant produces exactly one beat with `last`=1.
- `len`=24 with `beat_rdy_i` low for 5 cycles on `idx`=1 → `idx`=1, `bytes`=8 and id are held stable for those 5 cycles, then the transfer completes with `idx`=2 and `last`=1.
- `rst` asserted during `idx`=1 of a 4-beat transfer → the next cycle shows all outputs 0 and the FSM in IDLE; after reset, requester 0 wins over a simultaneous requester 3.
